// File: rtl/csr_access_unit_if.sv
// Request/response and CSR-file port bundle for the CSR access unit.
// The unit connects through the slave modport; the control side uses master.
interface csr_access_unit_if #(
  parameter int XLEN       = 32,
  parameter int CSR_ADDR_W = 12
);
  logic                  req_valid;
  logic                  req_ready;
  logic [2:0]            req_funct3;
  logic [4:0]            req_rs1uimm;
  logic [4:0]            req_rd;
  logic [CSR_ADDR_W-1:0] req_addr;
  logic [XLEN-1:0]       req_rs1_val;
  logic [1:0]            req_priv;
  logic                  flush;
  logic                  csr_re;
  logic [CSR_ADDR_W-1:0] csr_raddr;
  logic [XLEN-1:0]       csr_rdata;
  logic                  csr_we;
  logic [CSR_ADDR_W-1:0] csr_waddr;
  logic [XLEN-1:0]       csr_wdata;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [XLEN-1:0]       resp_rdata;
  logic                  resp_rd_we;
  logic                  resp_illegal;

  modport slave (
    input  req_valid, req_funct3, req_rs1uimm, req_rd, req_addr, req_rs1_val,
           req_priv, flush, csr_rdata, resp_ready,
    output req_ready, csr_re, csr_raddr, csr_we, csr_waddr, csr_wdata,
           resp_valid, resp_rdata, resp_rd_we, resp_illegal
  );

  modport master (
    output req_valid, req_funct3, req_rs1uimm, req_rd, req_addr, req_rs1_val,
           req_priv, flush, csr_rdata, resp_ready,
    input  req_ready, csr_re, csr_raddr, csr_we, csr_waddr, csr_wdata,
           resp_valid, resp_rdata, resp_rd_we, resp_illegal
  );
endinterface

// File: rtl/csr_access_unit.sv
// Sequenced Zicsr read-modify-write engine: decode, legality check, then
// CSR-file read / modify / write with the old value returned as the response.
module csr_access_unit #(
  parameter int XLEN         = 32,
  parameter int CSR_ADDR_W   = 12,
  parameter int READ_LATENCY = 1
) (
  input logic              clk,
  input logic              rst,
  csr_access_unit_if.slave bus
);
  localparam int CNT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  typedef enum logic [2:0] {IDLE, DECODE, READ, WAIT, WRITE, RESP} state_t;

  state_t                state_reg;
  logic                  ready_reg;
  logic [2:0]            funct3_reg;
  logic [4:0]            rs1uimm_reg;
  logic [4:0]            rd_reg;
  logic [CSR_ADDR_W-1:0] addr_reg;
  logic [XLEN-1:0]       rs1_val_reg;
  logic [1:0]            priv_reg;
  logic [XLEN-1:0]       old_reg;
  logic [CNT_W-1:0]      cnt_reg;
  logic                  csr_re_reg;
  logic                  csr_we_reg;
  logic [XLEN-1:0]       csr_wdata_reg;
  logic                  resp_valid_reg;
  logic [XLEN-1:0]       resp_rdata_reg;
  logic                  resp_rd_we_reg;
  logic                  resp_illegal_reg;

  logic                  op_bad;
  logic                  op_re;
  logic                  op_we;
  logic                  op_illegal;
  logic                  rd_nz;
  logic [XLEN-1:0]       operand;
  logic                  accept;

  // Decode runs off the captured request, so it is stable for the whole sequence.
  always_comb begin
    op_bad = (funct3_reg[1:0] == 2'b00);
    rd_nz  = (rd_reg != 5'd0);
    op_re  = 1'b1;
    op_we  = (rs1uimm_reg != 5'd0);
    if (funct3_reg[1:0] == 2'b01) begin
      op_we = 1'b1;
      op_re = rd_nz;
    end
    op_illegal = op_bad
              || (op_we && (addr_reg[CSR_ADDR_W-1 -: 2] == 2'b11))
              || (priv_reg < addr_reg[CSR_ADDR_W-3 -: 2]);
    operand = funct3_reg[2] ? XLEN'(rs1uimm_reg) : rs1_val_reg;
  end

  function automatic logic [XLEN-1:0] modify(input logic [1:0]      kind,
                                             input logic [XLEN-1:0] old_val,
                                             input logic [XLEN-1:0] opnd);
    case (kind)
      2'b10:   modify = old_val | opnd;
      2'b11:   modify = old_val & ~opnd;
      default: modify = opnd;
    endcase
  endfunction

  // A flush in IDLE withholds ready so no handshake appears to complete.
  assign bus.req_ready = ready_reg && !bus.flush;
  assign accept        = (state_reg == IDLE) && bus.req_valid && bus.req_ready;

  assign bus.csr_re       = csr_re_reg;
  assign bus.csr_raddr    = addr_reg;
  assign bus.csr_we       = csr_we_reg;
  assign bus.csr_waddr    = addr_reg;
  assign bus.csr_wdata    = csr_wdata_reg;
  assign bus.resp_valid   = resp_valid_reg;
  assign bus.resp_rdata   = resp_rdata_reg;
  assign bus.resp_rd_we   = resp_rd_we_reg;
  assign bus.resp_illegal = resp_illegal_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg        <= IDLE;
      ready_reg        <= 1'b1;
      funct3_reg       <= '0;
      rs1uimm_reg      <= '0;
      rd_reg           <= '0;
      addr_reg         <= '0;
      rs1_val_reg      <= '0;
      priv_reg         <= '0;
      old_reg          <= '0;
      cnt_reg          <= '0;
      csr_re_reg       <= 1'b0;
      csr_we_reg       <= 1'b0;
      csr_wdata_reg    <= '0;
      resp_valid_reg   <= 1'b0;
      resp_rdata_reg   <= '0;
      resp_rd_we_reg   <= 1'b0;
      resp_illegal_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            funct3_reg  <= bus.req_funct3;
            rs1uimm_reg <= bus.req_rs1uimm;
            rd_reg      <= bus.req_rd;
            addr_reg    <= bus.req_addr;
            rs1_val_reg <= bus.req_rs1_val;
            priv_reg    <= bus.req_priv;
            old_reg     <= '0;
            ready_reg   <= 1'b0;
            state_reg   <= DECODE;
          end
        end

        DECODE: begin
          if (bus.flush) begin
            ready_reg <= 1'b1;
            state_reg <= IDLE;
          end else if (op_illegal) begin
            resp_valid_reg   <= 1'b1;
            resp_rdata_reg   <= '0;
            resp_rd_we_reg   <= 1'b0;
            resp_illegal_reg <= 1'b1;
            state_reg        <= RESP;
          end else if (op_re) begin
            csr_re_reg <= 1'b1;
            state_reg  <= READ;
          end else begin
            // Write-only path is always a plain RW, so no old value is needed.
            csr_we_reg    <= 1'b1;
            csr_wdata_reg <= operand;
            state_reg     <= WRITE;
          end
        end

        READ: begin
          csr_re_reg <= 1'b0;
          if (bus.flush) begin
            ready_reg <= 1'b1;
            state_reg <= IDLE;
          end else begin
            cnt_reg   <= CNT_W'(READ_LATENCY - 1);
            state_reg <= WAIT;
          end
        end

        WAIT: begin
          if (bus.flush) begin
            ready_reg <= 1'b1;
            state_reg <= IDLE;
          end else if (cnt_reg == '0) begin
            old_reg <= bus.csr_rdata;
            if (op_we) begin
              csr_we_reg    <= 1'b1;
              csr_wdata_reg <= modify(funct3_reg[1:0], bus.csr_rdata, operand);
              state_reg     <= WRITE;
            end else begin
              resp_valid_reg   <= 1'b1;
              resp_rdata_reg   <= bus.csr_rdata;
              resp_rd_we_reg   <= rd_nz;
              resp_illegal_reg <= 1'b0;
              state_reg        <= RESP;
            end
          end else begin
            cnt_reg <= cnt_reg - CNT_W'(1);
          end
        end

        WRITE: begin
          // The strobe already went out this cycle; flush only drops the response.
          csr_we_reg <= 1'b0;
          if (bus.flush) begin
            ready_reg <= 1'b1;
            state_reg <= IDLE;
          end else begin
            resp_valid_reg   <= 1'b1;
            resp_rdata_reg   <= op_re ? old_reg : '0;
            resp_rd_we_reg   <= op_re && rd_nz;
            resp_illegal_reg <= 1'b0;
            state_reg        <= RESP;
          end
        end

        RESP: begin
          if (bus.flush || bus.resp_ready) begin
            resp_valid_reg   <= 1'b0;
            resp_rdata_reg   <= '0;
            resp_rd_we_reg   <= 1'b0;
            resp_illegal_reg <= 1'b0;
            ready_reg        <= 1'b1;
            state_reg        <= IDLE;
          end
        end

        default: begin
          csr_re_reg     <= 1'b0;
          csr_we_reg     <= 1'b0;
          resp_valid_reg <= 1'b0;
          ready_reg      <= 1'b1;
          state_reg      <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_csr_access_unit.sv
// Directed bench for csr_access_unit: one DUT at READ_LATENCY=1, one at 3,
// with a CSR-file model that presents read data only in the exact latency cycle.
module tb_csr_access_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  csr_access_unit_if #(.XLEN(32), .CSR_ADDR_W(12)) if1 ();
  csr_access_unit_if #(.XLEN(32), .CSR_ADDR_W(12)) if3 ();

  csr_access_unit #(.XLEN(32), .CSR_ADDR_W(12), .READ_LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst), .bus(if1));
  csr_access_unit #(.XLEN(32), .CSR_ADDR_W(12), .READ_LATENCY(3)) u_dut3 (
    .clk(clk), .rst(rst), .bus(if3));

  bit          sel = 1'b0;
  logic        b_valid = 1'b0;
  logic [2:0]  b_funct3 = '0;
  logic [4:0]  b_uimm = '0;
  logic [4:0]  b_rd = '0;
  logic [11:0] b_addr = '0;
  logic [31:0] b_rs1 = '0;
  logic [1:0]  b_priv = '0;
  logic        b_flush = 1'b0;
  logic        b_resp_ready = 1'b0;
  logic [31:0] csr_val = '0;
  logic [2:0]  pipe1 = '0;
  logic [2:0]  pipe3 = '0;

  int checks = 0;
  int errors = 0;
  int re_cnt = 0;
  int we_cnt = 0;
  int re_base = 0;
  int we_base = 0;
  logic [31:0] last_wdata = '0;
  logic [11:0] last_waddr = '0;
  logic [11:0] last_raddr = '0;
  bit overlap = 1'b0;

  assign if1.req_valid   = b_valid && !sel;
  assign if3.req_valid   = b_valid && sel;
  assign if1.req_funct3  = b_funct3;
  assign if3.req_funct3  = b_funct3;
  assign if1.req_rs1uimm = b_uimm;
  assign if3.req_rs1uimm = b_uimm;
  assign if1.req_rd      = b_rd;
  assign if3.req_rd      = b_rd;
  assign if1.req_addr    = b_addr;
  assign if3.req_addr    = b_addr;
  assign if1.req_rs1_val = b_rs1;
  assign if3.req_rs1_val = b_rs1;
  assign if1.req_priv    = b_priv;
  assign if3.req_priv    = b_priv;
  assign if1.flush       = b_flush;
  assign if3.flush       = b_flush;
  assign if1.resp_ready  = b_resp_ready && !sel;
  assign if3.resp_ready  = b_resp_ready && sel;

  // Read data is valid only L cycles after the strobe; otherwise a poison value.
  always @(posedge clk) begin
    pipe1 <= {pipe1[1:0], if1.csr_re};
    pipe3 <= {pipe3[1:0], if3.csr_re};
  end
  assign if1.csr_rdata = pipe1[0] ? csr_val : 32'hDEAD_BEEF;
  assign if3.csr_rdata = pipe3[2] ? csr_val : 32'hDEAD_BEEF;

  logic        o_req_ready, o_csr_re, o_csr_we, o_resp_valid, o_rd_we, o_illegal;
  logic [31:0] o_wdata, o_rdata;
  logic [11:0] o_waddr, o_raddr;
  assign o_req_ready  = sel ? if3.req_ready    : if1.req_ready;
  assign o_csr_re     = sel ? if3.csr_re       : if1.csr_re;
  assign o_csr_we     = sel ? if3.csr_we       : if1.csr_we;
  assign o_resp_valid = sel ? if3.resp_valid   : if1.resp_valid;
  assign o_rd_we      = sel ? if3.resp_rd_we   : if1.resp_rd_we;
  assign o_illegal    = sel ? if3.resp_illegal : if1.resp_illegal;
  assign o_wdata      = sel ? if3.csr_wdata    : if1.csr_wdata;
  assign o_rdata      = sel ? if3.resp_rdata   : if1.resp_rdata;
  assign o_waddr      = sel ? if3.csr_waddr    : if1.csr_waddr;
  assign o_raddr      = sel ? if3.csr_raddr    : if1.csr_raddr;

  always @(negedge clk) begin
    if (o_csr_re) begin
      re_cnt     <= re_cnt + 1;
      last_raddr <= o_raddr;
    end
    if (o_csr_we) begin
      we_cnt     <= we_cnt + 1;
      last_wdata <= o_wdata;
      last_waddr <= o_waddr;
    end
    if ((if1.csr_re && if1.csr_we) || (if3.csr_re && if3.csr_we)) overlap <= 1'b1;
  end

  task automatic issue(input bit s, input logic [2:0] f3, input logic [4:0] uimm,
                       input logic [4:0] rd, input logic [11:0] addr,
                       input logic [31:0] rs1, input logic [1:0] priv);
    @(negedge clk);
    sel = s; b_funct3 = f3; b_uimm = uimm; b_rd = rd;
    b_addr = addr; b_rs1 = rs1; b_priv = priv; b_valid = 1'b1;
    for (int i = 0; i < 20 && !o_req_ready; i++) @(negedge clk);
    re_base = re_cnt;
    we_base = we_cnt;
    @(posedge clk);
    #1 b_valid = 1'b0;
  endtask

  task automatic wait_resp(output int lat, output bit got);
    lat = 0;
    got = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      lat++;
      if (o_resp_valid) begin
        got = 1'b1;
        break;
      end
    end
    $display("txn dut=%0d f3=%b addr=%h got=%0d lat=%0d rdata=%h rd_we=%b illegal=%b",
             sel ? 3 : 1, b_funct3, b_addr, got, lat, o_rdata, o_rd_we, o_illegal);
  endtask

  task automatic accept_resp();
    b_resp_ready = 1'b1;
    @(posedge clk);
    #1 b_resp_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (if1.req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", if1.req_ready); end
    checks++; if (if1.csr_re !== 1'b0 || if1.csr_we !== 1'b0) begin errors++; $display("FAIL reset_strobes: got re=%b we=%b want 0 0", if1.csr_re, if1.csr_we); end
    checks++; if (if1.resp_valid !== 1'b0 || if1.resp_illegal !== 1'b0 || if1.resp_rd_we !== 1'b0) begin errors++; $display("FAIL reset_resp: got v=%b ill=%b rdwe=%b want 0", if1.resp_valid, if1.resp_illegal, if1.resp_rd_we); end
    checks++; if (if1.resp_rdata !== 32'h0 || if1.csr_wdata !== 32'h0) begin errors++; $display("FAIL reset_data: got rdata=%h wdata=%h want 0", if1.resp_rdata, if1.csr_wdata); end
    checks++; if (if1.csr_raddr !== 12'h0 || if1.csr_waddr !== 12'h0) begin errors++; $display("FAIL reset_addr: got %h %h want 0", if1.csr_raddr, if1.csr_waddr); end
    checks++; if (if3.req_ready !== 1'b1 || if3.resp_valid !== 1'b0) begin errors++; $display("FAIL reset_dut3: got ready=%b valid=%b want 1 0", if3.req_ready, if3.resp_valid); end
    rst = 1'b0;
  endtask

  task automatic test_csrrs();
    int lat; bit got;
    csr_val = 32'h1;
    issue(1'b0, 3'b010, 5'd5, 5'd3, 12'h300, 32'h8, 2'd3);
    wait_resp(lat, got);
    checks++; if (got !== 1'b1 || lat !== 5) begin errors++; $display("FAIL rs_latency: got got=%0d lat=%0d want 1 5", got, lat); end
    checks++; if (o_rdata !== 32'h1) begin errors++; $display("FAIL rs_rdata: got %h want 00000001", o_rdata); end
    checks++; if (o_rd_we !== 1'b1 || o_illegal !== 1'b0) begin errors++; $display("FAIL rs_flags: got rd_we=%b ill=%b want 1 0", o_rd_we, o_illegal); end
    accept_resp();
    checks++; if (re_cnt - re_base !== 1 || we_cnt - we_base !== 1) begin errors++; $display("FAIL rs_strobes: got re=%0d we=%0d want 1 1", re_cnt - re_base, we_cnt - we_base); end
    checks++; if (last_wdata !== 32'h9) begin errors++; $display("FAIL rs_wdata: got %h want 00000009", last_wdata); end
    checks++; if (last_waddr !== 12'h300 || last_raddr !== 12'h300) begin errors++; $display("FAIL rs_addr: got w=%h r=%h want 300", last_waddr, last_raddr); end
    checks++; if (o_resp_valid !== 1'b0 || o_req_ready !== 1'b1) begin errors++; $display("FAIL rs_done: got valid=%b ready=%b want 0 1", o_resp_valid, o_req_ready); end
  endtask

  task automatic test_csrrwi();
    int lat; bit got;
    csr_val = 32'h5555;
    issue(1'b0, 3'b101, 5'h1F, 5'd0, 12'h340, 32'hFFFF_FFFF, 2'd3);
    wait_resp(lat, got);
    checks++; if (got !== 1'b1 || lat !== 3) begin errors++; $display("FAIL rwi_latency: got got=%0d lat=%0d want 1 3", got, lat); end
    checks++; if (o_rdata !== 32'h0 || o_rd_we !== 1'b0 || o_illegal !== 1'b0) begin errors++; $display("FAIL rwi_resp: got rdata=%h rd_we=%b ill=%b want 0 0 0", o_rdata, o_rd_we, o_illegal); end
    accept_resp();
    checks++; if (re_cnt - re_base !== 0 || we_cnt - we_base !== 1) begin errors++; $display("FAIL rwi_strobes: got re=%0d we=%0d want 0 1", re_cnt - re_base, we_cnt - we_base); end
    checks++; if (last_wdata !== 32'h1F || last_waddr !== 12'h340) begin errors++; $display("FAIL rwi_write: got %h@%h want 0000001f@340", last_wdata, last_waddr); end
  endtask

  task automatic test_read_only_csr();
    int lat; bit got;
    csr_val = 32'h1234;
    issue(1'b0, 3'b011, 5'd0, 5'd5, 12'hC00, 32'hFFFF, 2'd0);
    wait_resp(lat, got);
    checks++; if (got !== 1'b1 || lat !== 4) begin errors++; $display("FAIL ro_read_latency: got got=%0d lat=%0d want 1 4", got, lat); end
    checks++; if (o_rdata !== 32'h1234 || o_rd_we !== 1'b1 || o_illegal !== 1'b0) begin errors++; $display("FAIL ro_read_resp: got rdata=%h rd_we=%b ill=%b want 00001234 1 0", o_rdata, o_rd_we, o_illegal); end
    accept_resp();
    checks++; if (re_cnt - re_base !== 1 || we_cnt - we_base !== 0) begin errors++; $display("FAIL ro_read_strobes: got re=%0d we=%0d want 1 0", re_cnt - re_base, we_cnt - we_base); end
    issue(1'b0, 3'b011, 5'd1, 5'd5, 12'hC00, 32'hFFFF, 2'd0);
    wait_resp(lat, got);
    checks++; if (got !== 1'b1 || lat !== 2) begin errors++; $display("FAIL ro_write_latency: got got=%0d lat=%0d want 1 2", got, lat); end
    checks++; if (o_illegal !== 1'b1 || o_rdata !== 32'h0 || o_rd_we !== 1'b0) begin errors++; $display("FAIL ro_write_resp: got ill=%b rdata=%h rd_we=%b want 1 0 0", o_illegal, o_rdata, o_rd_we); end
    accept_resp();
    checks++; if (re_cnt - re_base !== 0 || we_cnt - we_base !== 0) begin errors++; $display("FAIL ro_write_strobes: got re=%0d we=%0d want 0 0", re_cnt - re_base, we_cnt - we_base); end
  endtask

  task automatic test_illegal();
    int lat; bit got;
    issue(1'b0, 3'b010, 5'd5, 5'd3, 12'h300, 32'h8, 2'd0);
    wait_resp(lat, got);
    checks++; if (got !== 1'b1 || o_illegal !== 1'b1 || o_rdata !== 32'h0) begin errors++; $display("FAIL priv_resp: got got=%0d ill=%b rdata=%h want 1 1 0", got, o_illegal, o_rdata); end
    accept_resp();
    checks++; if (re_cnt - re_base !== 0 || we_cnt - we_base !== 0) begin errors++; $display("FAIL priv_strobes: got re=%0d we=%0d want 0 0", re_cnt - re_base, we_cnt - we_base); end
    issue(1'b0, 3'b100, 5'd5, 5'd3, 12'h300, 32'h8, 2'd3);
    wait_resp(lat, got);
    checks++; if (got !== 1'b1 || o_illegal !== 1'b1 || o_rd_we !== 1'b0) begin errors++; $display("FAIL f3_100_resp: got got=%0d ill=%b rd_we=%b want 1 1 0", got, o_illegal, o_rd_we); end
    accept_resp();
    checks++; if (re_cnt - re_base !== 0 || we_cnt - we_base !== 0) begin errors++; $display("FAIL f3_100_strobes: got re=%0d we=%0d want 0 0", re_cnt - re_base, we_cnt - we_base); end
  endtask

  task automatic test_modify_ops();
    int lat; bit got;
    csr_val = 32'hFF;
    issue(1'b0, 3'b011, 5'd2, 5'd1, 12'h305, 32'h0F, 2'd3);
    wait_resp(lat, got);
    checks++; if (got !== 1'b1 || o_rdata !== 32'hFF || o_rd_we !== 1'b1) begin errors++; $display("FAIL rc_resp: got got=%0d rdata=%h rd_we=%b want 1 000000ff 1", got, o_rdata, o_rd_we); end
    accept_resp();
    checks++; if (last_wdata !== 32'hF0 || we_cnt - we_base !== 1) begin errors++; $display("FAIL rc_wdata: got %h x%0d want 000000f0 x1", last_wdata, we_cnt - we_base); end
    csr_val = 32'h10;
    issue(1'b0, 3'b110, 5'd3, 5'd0, 12'h341, 32'hFFFF_0000, 2'd3);
    wait_resp(lat, got);
    checks++; if (got !== 1'b1 || o_rdata !== 32'h10 || o_rd_we !== 1'b0) begin errors++; $display("FAIL rsi_resp: got got=%0d rdata=%h rd_we=%b want 1 00000010 0", got, o_rdata, o_rd_we); end
    accept_resp();
    checks++; if (last_wdata !== 32'h13 || re_cnt - re_base !== 1) begin errors++; $display("FAIL rsi_wdata: got %h re=%0d want 00000013 1", last_wdata, re_cnt - re_base); end
  endtask

  task automatic test_latency3_backpressure();
    int lat; bit got;
    csr_val = 32'hA5;
    issue(1'b1, 3'b010, 5'd1, 5'd1, 12'h300, 32'h100, 2'd3);
    wait_resp(lat, got);
    checks++; if (got !== 1'b1 || lat !== 7) begin errors++; $display("FAIL l3_latency: got got=%0d lat=%0d want 1 7", got, lat); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (o_resp_valid !== 1'b1 || o_rdata !== 32'hA5 || o_rd_we !== 1'b1 || o_illegal !== 1'b0) begin
        errors++;
        $display("FAIL l3_hold%0d: got v=%b rdata=%h rd_we=%b ill=%b want 1 000000a5 1 0", i, o_resp_valid, o_rdata, o_rd_we, o_illegal);
      end
      @(negedge clk);
    end
    accept_resp();
    checks++; if (o_resp_valid !== 1'b0) begin errors++; $display("FAIL l3_release: got valid=%b want 0", o_resp_valid); end
    checks++; if (last_wdata !== 32'h1A5 || we_cnt - we_base !== 1) begin errors++; $display("FAIL l3_wdata: got %h x%0d want 000001a5 x1", last_wdata, we_cnt - we_base); end
    sel = 1'b0;
  endtask

  task automatic test_flush_wait();
    bit seen_re = 1'b0;
    bit seen_resp = 1'b0;
    csr_val = 32'h7;
    issue(1'b0, 3'b010, 5'd1, 5'd2, 12'h300, 32'h0, 2'd3);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (o_csr_re) begin
        seen_re = 1'b1;
        break;
      end
    end
    checks++; if (seen_re !== 1'b1) begin errors++; $display("FAIL flush_read_seen: got %b want 1", seen_re); end
    @(negedge clk);
    b_flush = 1'b1;
    @(posedge clk);
    #1 b_flush = 1'b0;
    @(negedge clk);
    checks++; if (o_req_ready !== 1'b1) begin errors++; $display("FAIL flush_ready: got %b want 1", o_req_ready); end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (o_resp_valid) seen_resp = 1'b1;
    end
    $display("txn dut=1 flush-in-wait resp_seen=%b we=%0d", seen_resp, we_cnt - we_base);
    checks++; if (seen_resp !== 1'b0 || we_cnt - we_base !== 0) begin errors++; $display("FAIL flush_no_effect: got resp=%b we=%0d want 0 0", seen_resp, we_cnt - we_base); end
  endtask

  task automatic test_reset_in_write();
    bit seen_we = 1'b0;
    bit seen_resp = 1'b0;
    issue(1'b0, 3'b101, 5'd4, 5'd0, 12'h340, 32'h0, 2'd3);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (o_csr_we) begin
        seen_we = 1'b1;
        break;
      end
    end
    checks++; if (seen_we !== 1'b1) begin errors++; $display("FAIL rstw_write_seen: got %b want 1", seen_we); end
    #2 rst = 1'b1;
    #1;
    checks++; if (o_csr_we !== 1'b0 || o_resp_valid !== 1'b0 || o_req_ready !== 1'b1) begin errors++; $display("FAIL rstw_immediate: got we=%b valid=%b ready=%b want 0 0 1", o_csr_we, o_resp_valid, o_req_ready); end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (o_resp_valid) seen_resp = 1'b1;
    end
    $display("txn dut=1 reset-in-write resp_seen=%b", seen_resp);
    checks++; if (seen_resp !== 1'b0) begin errors++; $display("FAIL rstw_no_resp: got %b want 0", seen_resp); end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    test_reset();
    test_csrrs();
    test_csrrwi();
    test_read_only_csr();
    test_illegal();
    test_modify_ops();
    test_latency3_backpressure();
    test_flush_wait();
    test_reset_in_write();
    checks++; if (overlap !== 1'b0) begin errors++; $display("FAIL re_we_overlap: got %b want 0", overlap); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
